cla_stream_acc: RTL and testbench
=================================

# cla_stream_acc

Streaming accumulator that sits directly upstream-consumer of `n_bit_cla`. It drives the adder's `a` and `b` operands from a running-sum register and an input stream, and consumes `s`/`cout` each accepted beat. It sums a length-programmed burst of N-bit operands and presents one result per burst on a valid/ready output port. It is the first sequential wrapper around the combinational CLA datapath.

## Interface
- `N`, 16, operand/sum width (passed to `n_bit_cla`)
- `CNT_W`, 8, width of burst-length field; max burst = 2^CNT_W − 1 operands

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, asynchronous and active-low
- `start`  in  1  begin a new burst; sampled only in IDLE
- `len`  in  CNT_W  number of operands in the burst, sampled with `start`
- `in_valid`  in  1  operand present
- `in_ready`  out  1  block accepts operand this cycle
- `in_data`  in  N  operand
- `out_valid`  out  1  result present
- `out_ready`  in  1  sink accepts result
- `out_sum`  out  N  accumulated sum
- `out_ovf`  out  1  sticky: any `cout`=1 during the burst
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, ACC, DONE.
- **IDLE:**
  - `start`=1 and `len`≠0 → ACC; acc←0, ovf←0, cnt←`len`.
  - `start`=1 and `len`=0 → DONE; acc=0, ovf=0.
- **ACC:**
  - `in_ready`=1.
  - Beat = `in_valid`&&`in_ready`.
  - Per beat: `n_bit_cla` a=acc, b=`in_data`, cin=0; acc←s; ovf←ovf|cout; cnt←cnt−1.
  - Beat with cnt=1 → DONE.
  - No beat → hold all state.
- **DONE:**
  - `out_valid`=1; `out_sum`=acc; `out_ovf`=ovf; outputs stable until handshake.
  - `out_valid`&&`out_ready` → IDLE.
- `start` is ignored outside IDLE.
- `in_ready`=0 outside ACC.
- Arithmetic is unsigned, modulo 2^N (unless the saturation option below is compiled in).
- `len` is captured; later changes to `len` have no effect.

## Timing
- Reset values:
  - state=IDLE; acc=0, ovf=0, cnt=0.
  - `in_ready`=0, `out_valid`=0, `out_sum`=0, `out_ovf`=0, `busy`=0.
- `start` in IDLE → `busy`=1 and `in_ready`=1 next cycle.
- Throughput is one operand per cycle in ACC.
- Latency: `out_valid` rises the cycle after the last beat is accepted.
- For `len`=0, `out_valid` rises the cycle after `start`.
- Output handshake accepted in DONE → `out_valid`=0 and IDLE next cycle. The earliest new `start` is sampled that cycle.
- Reset mid-burst (`rst_n` low in any state): immediate abort to reset values, partial sum discarded.
- `out_sum`/`out_ovf` are registered. There is no combinational path from `in_data` to outputs.

## Configuration
- Macro `CLA_ACC_SAT_EN`.
- **Defined:**
  - Saturating accumulation. A beat producing `cout`=1 sets acc←{N{1'b1}} and ovf←1.
  - Once saturated, acc stays all-ones for the rest of the burst.
- **Undefined:**
  - Wrap-around. acc←s (low N bits); ovf sticky as above.
- Interface and timing are identical in both builds.

## Structure
- Package `cla_pkg`: state enum typedef (IDLE/ACC/DONE) and default-width constants (`CLA_N_DEF`=16, `CLA_CNT_W_DEF`=8).
- One sub-module instance: `n_bit_cla #(.N(N))`, combinational adder in the ACC datapath.
- FSM, counter, acc/ovf registers and output registers live in `cla_stream_acc`.

## Test plan
Default parameters (N=16) unless stated.
1. `start`, `len`=3; operands 10, 20, 30 back-to-back with `out_ready`=1 → `out_valid` one cycle after third beat, `out_sum`=60, `out_ovf`=0, `busy`=0 the next cycle.
2. `len`=2; operands 0xFFFF, 0x0002:
   - Default build → `out_sum`=0x0001, `out_ovf`=1.
   - `CLA_ACC_SAT_EN` build → `out_sum`=0xFFFF, `out_ovf`=1.
3. `start` with `len`=0 → next cycle `out_valid`=1, `out_sum`=0, `out_ovf`=0, with no input beats consumed.
4. `len`=2; `in_valid` gaps of 3 cycles between beats (operands 5, 9); `out_ready` held low for 5 cycles in DONE → `out_sum`=14 held stable, `in_ready`=0, and a `start` pulse during DONE is ignored.
5. `len`=4; after 2 beats, pulse `rst_n` low → all outputs 0, state IDLE. Then `start` `len`=1, operand 7 → `out_sum`=7, `out_ovf`=0.
6. 200 random bursts (len 1–10, random data and valid/ready gaps) → `out_sum`/`out_ovf` match a reference model of the sum modulo 2^16 (saturated in the `CLA_ACC_SAT_EN` build).

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and default widths for the CLA streaming accumulator.
package cla_pkg;
  localparam int CLA_N_DEF     = 16;
  localparam int CLA_CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } cla_state_e;
endpackage

// File: rtl/n_bit_cla.sv
// Combinational N-bit carry-lookahead adder.
// Every carry is computed as a flat sum-of-products of generate/propagate terms.
module n_bit_cla #(
  parameter int N = 16
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] s,
  output logic         cout
);
  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
  always_comb begin
    logic prop;
    logic carry;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < N; i++) begin
      carry = g[i];
      prop  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        carry = carry | (prop & g[j]);
        prop  = prop & p[j];
      end
      c[i+1] = carry | (prop & cin);
    end
  end

  assign s    = p ^ c[N-1:0];
  assign cout = c[N];
endmodule

// File: rtl/cla_stream_acc.sv
// Burst accumulator around n_bit_cla: sums len operands, then presents one result.
// Build option: define CLA_ACC_SAT_EN for saturating instead of wrap-around accumulation.
module cla_stream_acc
  import cla_pkg::*;
#(
  parameter int N     = CLA_N_DEF,
  parameter int CNT_W = CLA_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_sum,
  output logic             out_ovf,
  output logic             busy,
  output logic [1:0]       state_dbg
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid and its payload stay stable until that edge, and ready
  // never depends combinationally on valid.

  cla_state_e       state_q, state_d;
  logic [N-1:0]     acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             beat;
  logic [N-1:0]     add_s;
  logic             add_cout;
  logic [N-1:0]     acc_nxt;

  n_bit_cla #(.N(N)) u_cla (
    .a    (acc_q),
    .b    (in_data),
    .cin  (1'b0),
    .s    (add_s),
    .cout (add_cout)
  );

`ifdef CLA_ACC_SAT_EN
  // Once saturated, any further add either carries again or adds zero, so acc stays all-ones.
  assign acc_nxt = add_cout ? {N{1'b1}} : add_s;
`else
  assign acc_nxt = add_s;
`endif

  assign beat = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          if (len != '0) begin
            cnt_d   = len;
            state_d = ACC;
          end else begin
            cnt_d   = '0;
            state_d = DONE;
          end
        end
      end
      ACC: begin
        if (beat) begin
          acc_d = acc_nxt;
          ovf_d = ovf_q | add_cout;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // All outputs decode registered state only; no path from in_data.
  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == DONE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;
endmodule

// File: tb/tb_cla_stream_acc.sv
// Self-checking bench for cla_stream_acc with an expected-result queue.
module tb_cla_stream_acc;
  import cla_pkg::*;

  localparam int N     = 16;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [CNT_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_data;
  logic             out_valid;
  logic             out_ready;
  logic [N-1:0]     out_sum;
  logic             out_ovf;
  logic             busy;
  logic [1:0]       state_dbg;

  int total = 0;
  int bad   = 0;

  logic [N-1:0] exp_q[$];
  logic         exp_ovf_q[$];
  logic [N-1:0] op_q[$];

  cla_stream_acc #(.N(N), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  // reference model: unsigned sum, wrapping or saturating on carry-out
  task automatic push_model(input int n);
    int unsigned s;
    logic o;
    s = 0;
    o = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = s + 32'(op_q[i]);
      if (s > 32'hFFFF) begin
        o = 1'b1;
`ifdef CLA_ACC_SAT_EN
        s = 32'hFFFF;
`else
        s = s & 32'hFFFF;
`endif
      end
    end
    exp_q.push_back(s[N-1:0]);
    exp_ovf_q.push_back(o);
  endtask

  // Driver: called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic do_burst(input int n, input int gap_max, input int fixed_gap,
                          input int stall, input bit start_in_done);
    int gap;
    logic [N-1:0] held;
    logic [N-1:0] e_sum;
    logic e_ovf;
    start = 1'b1;
    len = CNT_W'(n);
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    len = CNT_W'($urandom_range(0, 255));
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL busy_after_start: got %0b want 1", busy);
    end
    total++;
    if (in_ready !== (n != 0)) begin
      bad++; $display("FAIL in_ready_after_start: got %0b want %0b", in_ready, (n != 0));
    end
    for (int i = 0; i < n; i++) begin
      gap = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : ((i == 0) ? 0 : fixed_gap);
      repeat (gap) begin
        in_data = N'($urandom);
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data = op_q[i];
      total++;
      if (in_ready !== 1'b1) begin
        bad++; $display("FAIL beat_ready: beat %0d got in_ready=%0b want 1", i, in_ready);
      end
      @(negedge clk);
      in_valid = 1'b0;
      in_data = N'($urandom);
      if (i < n - 1) begin
        total++;
        if (out_valid !== 1'b0) begin
          bad++; $display("FAIL early_valid: beat %0d got out_valid=%0b want 0", i, out_valid);
        end
      end
    end
    total++;
    if (out_valid !== 1'b1) begin
      bad++; $display("FAIL valid_latency: got out_valid=%0b want 1", out_valid);
    end
    for (int k = 0; k < 20 && out_valid !== 1'b1; k++) @(negedge clk);
    held = out_sum;
    for (int k = 0; k < stall; k++) begin
      if (start_in_done && k == 1) begin
        start = 1'b1;
        len = CNT_W'(5);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== held) begin
        bad++;
        $display("FAIL stall_hold: got valid=%0b rdy=%0b sum=%0h want valid=1 rdy=0 sum=%0h",
                 out_valid, in_ready, out_sum, held);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    // scoreboard pop at the output handshake
    total++;
    if (exp_q.size() == 0) begin
      bad++; $display("FAIL scoreboard_empty: got result %0h want none queued", out_sum);
    end else begin
      e_sum = exp_q.pop_front();
      e_ovf = exp_ovf_q.pop_front();
      if (out_sum !== e_sum || out_ovf !== e_ovf) begin
        bad++;
        $display("FAIL result: got sum=%0h ovf=%0b want sum=%0h ovf=%0b",
                 out_sum, out_ovf, e_sum, e_ovf);
      end
    end
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || state_dbg !== 2'(IDLE)) begin
      bad++;
      $display("FAIL post_handshake: got valid=%0b busy=%0b state=%0d want 0 0 %0d",
               out_valid, busy, state_dbg, IDLE);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    len = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({in_ready, out_valid, out_sum, out_ovf, busy} !== '0 || state_dbg !== 2'(IDLE)) begin
      bad++;
      $display("FAIL reset_values: got rdy=%0b vld=%0b sum=%0h ovf=%0b busy=%0b state=%0d want all 0",
               in_ready, out_valid, out_sum, out_ovf, busy, state_dbg);
    end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL idle_after_reset: got busy=%0b vld=%0b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_basic();
    op_q = '{16'd10, 16'd20, 16'd30};
    exp_q.push_back(16'd60);
    exp_ovf_q.push_back(1'b0);
    do_burst(3, 0, 0, 0, 1'b0);
  endtask

  task automatic test_overflow();
    op_q = '{16'hFFFF, 16'h0002};
`ifdef CLA_ACC_SAT_EN
    exp_q.push_back(16'hFFFF);
`else
    exp_q.push_back(16'h0001);
`endif
    exp_ovf_q.push_back(1'b1);
    do_burst(2, 0, 0, 0, 1'b0);
  endtask

  task automatic test_len_zero();
    op_q.delete();
    exp_q.push_back(16'd0);
    exp_ovf_q.push_back(1'b0);
    do_burst(0, 0, 0, 2, 1'b0);
  endtask

  task automatic test_gaps_stall();
    op_q = '{16'd5, 16'd9};
    exp_q.push_back(16'd14);
    exp_ovf_q.push_back(1'b0);
    do_burst(2, 0, 3, 5, 1'b1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1;
    len = CNT_W'(4);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data = 16'h4000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    total++;
    if ({in_ready, out_valid, out_sum, out_ovf, busy} !== '0 || state_dbg !== 2'(IDLE)) begin
      bad++;
      $display("FAIL reset_mid: got rdy=%0b vld=%0b sum=%0h ovf=%0b busy=%0b state=%0d want all 0",
               in_ready, out_valid, out_sum, out_ovf, busy, state_dbg);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op_q = '{16'd7};
    exp_q.push_back(16'd7);
    exp_ovf_q.push_back(1'b0);
    do_burst(1, 0, 0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    op_q = '{16'h8000, 16'h8000, 16'h0003};
    push_model(3);
    do_burst(3, 0, 0, 0, 1'b0);
    op_q = '{16'h1234, 16'h0001};
    push_model(2);
    do_burst(2, 0, 0, 1, 1'b0);
  endtask

  task automatic test_random();
    int n;
    for (int b = 0; b < 200; b++) begin
      n = int'($urandom_range(1, 10));
      op_q.delete();
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) op_q.push_back(N'($urandom_range(16'hF000, 16'hFFFF)));
        else op_q.push_back(N'($urandom));
      end
      push_model(n);
      do_burst(n, 2, 0, int'($urandom_range(0, 3)), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_len_zero();
    test_gaps_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover: got %0d queued want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
